// File: rtl/fir_seq_pkg.sv
// Shared constants and FSM state type for the FIR sequencer.
// The FLUSH state only exists when FIR_SEQ_FLUSH_EN is defined.
package fir_seq_pkg;

  localparam int unsigned NUM_TAPS   = 5;
  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned FIR_LAT    = 2;
  localparam int unsigned FLUSH_LEN  = 4;
  localparam int unsigned PIPE_DEPTH = RD_LAT + 1 + FIR_LAT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
`ifdef FIR_SEQ_FLUSH_EN
    ST_FLUSH,
`endif
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fir_seq_dly.sv
// Valid + index delay pipe; aligns each issued sample slot with its
// FIR result so the destination write strobe and address line up.
module fir_seq_dly #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DEPTH-1:0]  valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = {valid_q[DEPTH-2:0], in_valid};
    data_d  = {data_q[DEPTH-2:0], in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer streaming N samples from a source BRAM through a 5-tap FIR
// into a destination BRAM. Define FIR_SEQ_FLUSH_EN to append 4 zero samples.
module fir_seq_ctrl
  import fir_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tap0,
  output logic [7:0]        tap1,
  output logic [7:0]        tap2,
  output logic [7:0]        tap3,
  output logic [7:0]        tap4,
  input  logic [7:0]        fir_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int unsigned SHIFT_STG = RD_LAT - 1;
  localparam int unsigned WR_STG    = PIPE_DEPTH - 1;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          len_q, len_d;
  logic [ADDR_W-1:0]          src_q, src_d;
  logic [ADDR_W-1:0]          dst_q, dst_d;
  logic [ADDR_W-1:0]          cnt_q, cnt_d;
  logic [NUM_TAPS-1:0][7:0]   taps_q, taps_d;
  logic                       accept_run;
  logic                       slot_valid;
  logic                       pending;
  logic [PIPE_DEPTH-1:0]      pipe_valid;
  logic [ADDR_W-1:0]          pipe_idx;

`ifdef FIR_SEQ_FLUSH_EN
  localparam logic [ADDR_W-1:0] FLUSH_LAST = ADDR_W'(FLUSH_LEN - 1);
  logic                       slot_zero;
  logic                       zero_q;
  logic [ADDR_W-1:0]          flush_end;
  assign flush_end = len_q + FLUSH_LAST;
`endif

  // Slot index keeps counting through FLUSH so tail writes land at dst_base+N..
  fir_seq_dly #(
    .DEPTH  (PIPE_DEPTH),
    .DATA_W (ADDR_W)
  ) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (slot_valid),
    .in_data  (cnt_q),
    .valid_o  (pipe_valid),
    .data_o   (pipe_idx)
  );

  assign pending = |pipe_valid[WR_STG-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      taps_q  <= '0;
`ifdef FIR_SEQ_FLUSH_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      taps_q  <= taps_d;
`ifdef FIR_SEQ_FLUSH_EN
      zero_q  <= slot_zero;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    accept_run = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_RUN;
            accept_run = 1'b1;
            len_d      = len;
            src_d      = src_base;
            dst_d      = dst_base;
            cnt_d      = '0;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == len_q - 1'b1) begin
`ifdef FIR_SEQ_FLUSH_EN
          state_d = ST_FLUSH;
`else
          state_d = ST_DRAIN;
`endif
        end
      end
`ifdef FIR_SEQ_FLUSH_EN
      ST_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == flush_end) state_d = ST_DRAIN;
      end
`endif
      ST_DRAIN: begin
        if (!pending) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    slot_valid = 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
    slot_zero  = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        busy       = 1'b1;
        rd_en      = 1'b1;
        slot_valid = 1'b1;
      end
`ifdef FIR_SEQ_FLUSH_EN
      ST_FLUSH: begin
        busy       = 1'b1;
        slot_valid = 1'b1;
        slot_zero  = 1'b1;
      end
`endif
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
    rd_addr = rd_en ? src_q + cnt_q : '0;
    wr_en   = pipe_valid[WR_STG];
    wr_addr = wr_en ? dst_q + pipe_idx : '0;
    wr_data = wr_en ? fir_out : '0;
  end

  // Shift happens when the slot's BRAM data arrives (RD_LAT == 1 stage).
  always_comb begin
    taps_d = taps_q;
    if (accept_run) begin
      taps_d = '0;
    end else if (pipe_valid[SHIFT_STG]) begin
      for (int unsigned k = 1; k < NUM_TAPS; k++) taps_d[k] = taps_q[k-1];
`ifdef FIR_SEQ_FLUSH_EN
      taps_d[0] = zero_q ? '0 : rd_data;
`else
      taps_d[0] = rd_data;
`endif
    end
  end

  assign tap0 = taps_q[0];
  assign tap1 = taps_q[1];
  assign tap2 = taps_q[2];
  assign tap3 = taps_q[3];
  assign tap4 = taps_q[4];

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl with BRAM and pipelined FIR models.
`timescale 1ns/1ps
module tb_fir_seq_ctrl;

  localparam int unsigned AW  = 10;
  localparam int unsigned MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0, src_base = '0, dst_base = '0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data = '0;
  logic [7:0]    tap0, tap1, tap2, tap3, tap4;
  logic [7:0]    fir_out = '0;
  logic [7:0]    wr_data;
  logic [11:0]   fir_s1 = '0;
  logic [7:0]    src_mem [MEM];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned busy_lo = 1, busy_hi = 0;
  int unsigned coef [5] = '{1, 2, 3, 2, 1};

  typedef struct {
    int unsigned cyc;
    int unsigned addr;
    int unsigned data;
  } exp_t;

  exp_t        rd_q[$];
  exp_t        wr_q[$];
  int unsigned done_q[$];

  fir_seq_ctrl #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .src_base (src_base),
    .dst_base (dst_base),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tap0     (tap0),
    .tap1     (tap1),
    .tap2     (tap2),
    .tap3     (tap3),
    .tap4     (tap4),
    .fir_out  (fir_out),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

  always @(posedge clk) begin
    fir_s1  <= 12'(tap0) + 12'(tap1) * 12'd2 + 12'(tap2) * 12'd3
             + 12'(tap3) * 12'd2 + 12'(tap4);
    fir_out <= fir_s1[7:0];
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (rd_en) begin
        if (rd_q.size() == 0) chk("spurious rd_en", 32'(rd_en), 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", 32'(rd_addr), e.addr);
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) chk("spurious wr_en", 32'(wr_en), 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", 32'(wr_addr), e.addr);
          chk("wr_data", 32'(wr_data), e.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("spurious done", 32'(done), 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  // Reference: y[j] = sum coef[k]*x[j-k], samples outside 0..n-1 are zero.
  task automatic launch(input int unsigned n, input int unsigned sb, input int unsigned db,
                        input bit release_rst, input bit repulse);
    int unsigned x[$];
    int unsigned p0, w, y;
    exp_t        e;
    @(negedge clk);
    p0 = cyc + 1;
    for (int unsigned i = 0; i < n; i++) begin
      x.push_back(32'(src_mem[(sb + i) % MEM]));
      e.cyc = p0 + i; e.addr = (sb + i) % MEM; e.data = 0;
      rd_q.push_back(e);
    end
    w = n;
`ifdef FIR_SEQ_FLUSH_EN
    if (n != 0) w = n + 4;
`endif
    for (int unsigned j = 0; j < w; j++) begin
      y = 0;
      for (int unsigned k = 0; k < 5; k++)
        if (j >= k && (j - k) < n) y += coef[k] * x[j - k];
      e.cyc = p0 + 4 + j; e.addr = (db + j) % MEM; e.data = y % 256;
      wr_q.push_back(e);
    end
    done_q.push_back(n == 0 ? p0 : p0 + 4 + w);
    if (n != 0) begin
      busy_lo = p0;
      busy_hi = p0 + 3 + w;
    end
    if (release_rst) rst_n = 1'b1;
    len = AW'(n); src_base = AW'(sb); dst_base = AW'(db);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = AW'($urandom); src_base = AW'($urandom); dst_base = AW'($urandom);
    if (repulse) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_idle(input int unsigned budget);
    for (int unsigned i = 0; i < budget && (done_q.size() != 0 || wr_q.size() != 0); i++)
      @(negedge clk);
    chk("run_complete", done_q.size() + wr_q.size() + rd_q.size(), 0);
  endtask

  task automatic fill(input int unsigned n, input int unsigned sb);
    for (int unsigned i = 0; i < n; i++) src_mem[(sb + i) % MEM] = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int unsigned i = 0; i < MEM; i++) src_mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset rd_en", 32'(rd_en), 0);
    chk("reset wr_en", 32'(wr_en), 0);
    chk("reset taps", 32'(|{tap0, tap1, tap2, tap3, tap4}), 0);

    for (int unsigned i = 0; i < 5; i++) src_mem[i] = 8'(i + 1);
    launch(5, 0, 'h100, 1'b1, 1'b0);
    wait_idle(40);

    launch(0, 'h20, 'h200, 1'b0, 1'b0);
    wait_idle(10);

    src_mem['h3FE] = 8'd2; src_mem['h3FF] = 8'd2; src_mem[0] = 8'd2; src_mem[1] = 8'd2;
    launch(4, 'h3FE, 'h3FF, 1'b0, 1'b0);
    wait_idle(40);

    fill(6, 'h40);
    launch(6, 'h40, 'h140, 1'b0, 1'b1);
    wait_idle(40);

    fill(20, 'h50);
    launch(20, 'h50, 'h180, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset rd_en", 32'(rd_en), 0);
    chk("async reset wr_en", 32'(wr_en), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset rd_addr", 32'(rd_addr), 0);
    chk("async reset taps", 32'(|{tap0, tap1, tap2, tap3, tap4}), 0);
    rd_q.delete(); wr_q.delete(); done_q.delete();
    busy_lo = 1; busy_hi = 0;
    repeat (2) @(negedge clk);
    fill(7, 'h90);
    launch(7, 'h90, 'h300, 1'b1, 1'b0);
    wait_idle(40);

    for (int r = 0; r < 10; r++) begin
      int unsigned n, sb, db;
      n  = $urandom_range(0, 16);
      sb = $urandom_range(0, MEM - 1);
      db = $urandom_range(0, MEM - 1);
      fill(n, sb);
      launch(n, sb, db, 1'b0, r % 3 == 1);
      wait_idle(60);
    end

    repeat (6) @(negedge clk);
    chk("final queues empty", rd_q.size() + wr_q.size() + done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: BRAM address width for source and destination buffers.
REQ-002 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n  in  1: reset, asynchronous and active-low.
REQ-004 Port start  in  1: one-cycle request to begin a run; sampled only in IDLE.
REQ-005 Port len  in  ADDR_W: sample count N, captured on accepted start.
REQ-006 Port src_base, dst_base  in  ADDR_W each: source and destination base addresses, captured on accepted start.
REQ-007 Port busy  out  1: high from the cycle after an accepted start until the done cycle.
REQ-008 Port done  out  1: one-cycle completion pulse.
REQ-009 Port rd_en  out  1, rd_addr  out  ADDR_W, rd_data  in  8: source BRAM read port; rd_data is valid exactly 1 cycle after rd_en.
REQ-010 Port tap0..tap4  out  8 each: registered delay line x[n]..x[n-4] driving the pipelined FIR (coefficients 1,2,3,2,1; 2-cycle latency).
REQ-011 Port fir_out  in  8: FIR filtered output.
REQ-012 Port wr_en  out  1, wr_addr  out  ADDR_W, wr_data  out  8: destination BRAM write port.

Function
REQ-013 States: IDLE, RUN, FLUSH (macro builds only), DRAIN, DONE.
REQ-014 IDLE + start with len!=0: clear tap0..tap4 to 0, capture len/bases, go to RUN; start with len==0 goes directly to DONE with no reads or writes.
REQ-015 RUN: assert rd_en for exactly N consecutive cycles with rd_addr = src_base+i, i=0..N-1, modulo 2^ADDR_W; then go to FLUSH (macro) or DRAIN.
REQ-016 One cycle after each rd_en, the delay line shifts: tap0<=rd_data, tapk<=tap(k-1).
REQ-017 Each sample's write occurs 4 cycles after its rd_en: 1 cycle BRAM, 1 cycle tap register, 2 cycles FIR.
REQ-018 On that cycle: wr_en=1, wr_data=fir_out, wr_addr=dst_base+i modulo 2^ADDR_W; one write per cycle, in order, no gaps.
REQ-019 DRAIN: hold until the final write has issued, then go to DONE; DONE lasts 1 cycle with done=1, then returns to IDLE.
REQ-020 start while busy is ignored; len/base changes while busy have no effect.
REQ-021 Samples before index 0 contribute zero, guaranteed by the clear in REQ-014.
REQ-022 The block SHALL NOT stall; FIR has no enable, so issue and write timing are fixed once RUN begins.

Reset
REQ-023 rst_n low, including mid-run: state IDLE, busy=0, done=0, rd_en=0, wr_en=0, all addresses/taps/counters/valid pipe 0; in-flight samples are discarded without writes.
REQ-024 After rst_n deasserts, the first start is accepted on the first rising edge.

Configuration
REQ-025 Macro FIR_SEQ_FLUSH_EN defined: after RUN, FLUSH injects 4 zero samples in consecutive cycles.
REQ-026 Each injected zero takes an rd_en slot with rd_en held low and tap0 loaded with 0.
REQ-027 With FIR_SEQ_FLUSH_EN, N+4 writes occur (tail to dst_base+N..N+3); len==0 still writes nothing.
REQ-028 Macro undefined: FLUSH state and logic are absent, and exactly N writes occur.

Structure
REQ-029 Package fir_seq_pkg holds NUM_TAPS=5, RD_LAT=1, FIR_LAT=2, FLUSH_LEN=4 and the state enum type.
REQ-030 Sub-module fir_seq_dly: a parameterised valid+index delay pipe of depth RD_LAT+1+FIR_LAT that aligns write strobes and addresses; all else is in fir_seq_ctrl.

Verification (bench includes the pipelined FIR datapath and two BRAM models)
REQ-031 N=5, src=[1,2,3,4,5], src_base=0, dst_base=0x100, no macro -> dst[0x100..0x104]=[1,4,10,18,27]; done one cycle after the last write; reads span 5 cycles and writes span 5 consecutive cycles starting 4 cycles after the first rd_en.
REQ-032 Same stimulus with FIR_SEQ_FLUSH_EN -> dst[0x100..0x108]=[1,4,10,18,27,30,26,14,5]; no rd_en during FLUSH.
REQ-033 len=0 start -> done pulses the next cycle, no rd_en or wr_en, busy never high.
REQ-034 src_base=0x3FE, dst_base=0x3FF, N=4, src=[2,2,2,2] -> reads 0x3FE,0x3FF,0x000,0x001; dst writes 0x3FF,0x000,0x001,0x002 = [2,6,12,16].
REQ-035 start re-pulsed during RUN -> ignored, one done only; rst_n low mid-RUN -> outputs 0 immediately (asynchronously), no further writes; the next run's first outputs show no stale tap data.
